// File: rtl/accum_xcel_mem_unit.sv
// Memory-side stage of the accumulator: turns request strobes into addressed
// word loads, bounds loads in flight, and sums the returned data.
module accum_xcel_mem_unit #(
  parameter int QDEPTH  = 4,
  parameter int MAX_OUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        req_strobe,
  input  logic        load_done,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic [31:0] memreq_addr,
  input  logic        memresp_val,
  output logic        memresp_rdy,
  input  logic [31:0] memresp_data,
  output logic [31:0] result,
  output logic        result_val,
  output logic        overflow,
  output logic        busy
);

  localparam int AW = $clog2(QDEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [13:0]   cnt_q, cnt_d;
  logic [31:0]   mem_q [QDEPTH];
  logic [31:0]   mem_d [QDEPTH];
  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   rp_q, rp_d;
  logic [OW-1:0] out_q, out_d;
  logic [31:0]   sum_q, sum_d;
  logic          ovf_q, ovf_d;
  logic          rv_q, rv_d;

  logic empty, full, fire, accept, push;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign memresp_rdy = busy;
  assign memreq_val  = !empty && (out_q < OW'(MAX_OUT));
  assign memreq_addr = mem_q[rp_q[AW-1:0]];
  assign fire        = memreq_val && memreq_rdy;
  assign accept      = memresp_val && memresp_rdy;
  assign push        = (state_q == RUN) && req_strobe && !full;
  assign result      = sum_q;
  assign result_val  = rv_q;
  assign overflow    = ovf_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    out_d   = out_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    rv_d    = (state_q == DONE) && !start;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          base_d  = base_addr;
          cnt_d   = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (load_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty && out_q == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == RUN) && req_strobe && full) ovf_d = 1'b1;

    if (push) begin
      mem_d[wp_q[AW-1:0]] = base_q + {16'd0, cnt_q, 2'b00};
      wp_d  = wp_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
    end

    if (fire) rp_d = rp_q + 1'b1;

    unique case ({fire, accept})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    if (accept) sum_d = sum_q + memresp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      out_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      out_q   <= out_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      rv_q    <= rv_d;
    end
  end

endmodule

// File: tb/tb_accum_xcel_mem_unit.sv
// Directed bench for accum_xcel_mem_unit with a latency-configurable
// in-order memory model.
module tb_accum_xcel_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        req_strobe;
  logic        load_done;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [31:0] memreq_addr;
  logic        memresp_val;
  logic        memresp_rdy;
  logic [31:0] memresp_data;
  logic [31:0] result;
  logic        result_val;
  logic        overflow;
  logic        busy;

  accum_xcel_mem_unit #(.QDEPTH(4), .MAX_OUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .req_strobe(req_strobe), .load_done(load_done),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memreq_addr(memreq_addr), .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy), .memresp_data(memresp_data),
    .result(result), .result_val(result_val),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  rsp_t        pend[$];
  logic [31:0] tab[$];
  logic [31:0] fired[$];
  rsp_t        nr;
  int          cyc = 0;
  int          lat = 1;
  int          passed = 0;
  int          total = 0;

  // Memory model: observe handshakes mid-cycle, present responses after edge.
  always @(negedge clk) begin
    if (memresp_val && memresp_rdy && pend.size() > 0)
      void'(pend.pop_front());
    if (memreq_val && memreq_rdy) begin
      fired.push_back(memreq_addr);
      nr.due = cyc + lat;
      nr.d   = (tab.size() > 0) ? tab.pop_front() : 32'h0;
      pend.push_back(nr);
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      memresp_val  = 1'b1;
      memresp_data = pend[0].d;
    end else begin
      memresp_val  = 1'b0;
      memresp_data = 32'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic wait_rv(input int n);
    int k;
    k = 0;
    while (!result_val && k < n) begin
      tick();
      k++;
    end
    chk("result_val_timeout", {31'd0, result_val}, 32'd1);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      req_strobe = 1'b1;
      tick();
    end
    req_strobe = 1'b0;
  endtask

  task automatic go(input logic [31:0] b);
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    fired.delete();
  endtask

  task automatic finish_run();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  initial begin
    memresp_val  = 1'b0;
    memresp_data = 32'h0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = 32'h0;
    req_strobe = 1'b0;
    load_done = 1'b0;
    memreq_rdy = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rv", {31'd0, result_val}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_reqval", {31'd0, memreq_val}, 32'd0);
    chk("rst_resprdy", {31'd0, memresp_rdy}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: four loads, 1-cycle latency
    lat = 1;
    tab = '{32'd1, 32'd2, 32'd3, 32'd4};
    memreq_rdy = 1'b1;
    go(32'h1000);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_noreq_before", {31'd0, memreq_val}, 32'd0);
    req_strobe = 1'b1;
    tick();
    chk("t1_req_next_cycle", {31'd0, memreq_val}, 32'd1);
    strobes(3);
    finish_run();
    wait_rv(30);
    chk("t1_result", result, 32'd10);
    chk("t1_ovf", {31'd0, overflow}, 32'd0);
    chk("t1_nfired", fired.size(), 32'd4);
    chk("t1_a0", fired[0], 32'h1000);
    chk("t1_a1", fired[1], 32'h1004);
    chk("t1_a2", fired[2], 32'h1008);
    chk("t1_a3", fired[3], 32'h100C);

    // 2: back-pressure, queue overflow
    memreq_rdy = 1'b0;
    tab = '{32'd5, 32'd6, 32'd7, 32'd8};
    go(32'h0);
    chk("t2_rv_cleared", {31'd0, result_val}, 32'd0);
    strobes(6);
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    chk("t2_val_held", {31'd0, memreq_val}, 32'd1);
    chk("t2_addr_held", memreq_addr, 32'h0);
    chk("t2_none_fired", fired.size(), 32'd0);
    memreq_rdy = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("t2_nfired", fired.size(), 32'd4);
    chk("t2_a0", fired[0], 32'h0);
    chk("t2_a1", fired[1], 32'h4);
    chk("t2_a2", fired[2], 32'h8);
    chk("t2_a3", fired[3], 32'hC);
    finish_run();
    wait_rv(30);
    chk("t2_result", result, 32'd26);
    chk("t2_ovf_sticky", {31'd0, overflow}, 32'd1);

    // 3: long latency, in-flight cap of 8
    lat = 20;
    tab = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5,
            32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
    go(32'h0);
    chk("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
    strobes(10);
    chk("t3_capped_val", {31'd0, memreq_val}, 32'd0);
    chk("t3_capped_n", fired.size(), 32'd8);
    finish_run();
    wait_rv(100);
    chk("t3_result", result, 32'd55);
    chk("t3_nfired", fired.size(), 32'd10);
    chk("t3_last_addr", fired[9], 32'h24);

    // 4: load_done with strobe, responses still pending in DRAIN
    lat = 6;
    tab = '{32'd3, 32'd4};
    go(32'h2000);
    req_strobe = 1'b1;
    tick();
    load_done = 1'b1;
    tick();
    req_strobe = 1'b0;
    load_done = 1'b0;
    tick();
    chk("t4_drain_busy", {31'd0, busy}, 32'd1);
    chk("t4_drain_rv", {31'd0, result_val}, 32'd0);
    tick();
    tick();
    chk("t4_drain_busy2", {31'd0, busy}, 32'd1);
    chk("t4_drain_rv2", {31'd0, result_val}, 32'd0);
    wait_rv(40);
    chk("t4_result", result, 32'd7);
    chk("t4_nfired", fired.size(), 32'd2);
    chk("t4_a1", fired[1], 32'h2004);

    // 5: sum wrap, then restart from DONE
    lat = 1;
    tab = '{32'hFFFF_FFFF, 32'h0000_0002};
    go(32'h0);
    strobes(2);
    finish_run();
    wait_rv(30);
    chk("t5_wrap", result, 32'h1);
    go(32'h3000);
    chk("t5_restart_rv", {31'd0, result_val}, 32'd0);
    chk("t5_restart_sum", result, 32'd0);
    chk("t5_restart_busy", {31'd0, busy}, 32'd1);
    finish_run();
    wait_rv(30);
    chk("t5_empty_run", result, 32'd0);

    // 6: async reset mid-DRAIN with loads outstanding
    lat = 30;
    tab = '{32'd9, 32'd9, 32'd9};
    go(32'h4000);
    strobes(3);
    finish_run();
    tick();
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    chk("t6_all_fired", fired.size(), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_rv", {31'd0, result_val}, 32'd0);
    chk("t6_result", result, 32'd0);
    chk("t6_ovf", {31'd0, overflow}, 32'd0);
    chk("t6_reqval", {31'd0, memreq_val}, 32'd0);
    chk("t6_addr", memreq_addr, 32'd0);
    chk("t6_resprdy", {31'd0, memresp_rdy}, 32'd0);
    #1;
    rst = 1'b0;
    begin
      int k;
      k = 0;
      while (!memresp_val && k < 60) begin
        tick();
        k++;
      end
    end
    chk("t6_late_resp_seen", {31'd0, memresp_val}, 32'd1);
    chk("t6_late_refused", {31'd0, memresp_rdy}, 32'd0);
    tick();
    chk("t6_sum_kept_zero", result, 32'd0);
    chk("t6_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
